iob_diff_n: RTL and testbench

//  Streaming N-th order differentiator with CHANNELS time-interleaved channels.

---
 rtl/iob_diff_n_pkg.sv | 20 ++
 rtl/iob_diff_n_stage.sv | 19 +
 rtl/iob_diff_n.sv | 103 ++++++++++
 tb/tb_iob_diff_n.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/iob_diff_n_pkg.sv
// Shared constants and width helpers for the N-th order streaming differentiator.
package iob_diff_n_pkg;

  localparam int MAX_ORDER = 4;
  localparam int PCNT_W    = 3;

  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Width of the k-th difference of a data_w-bit stream
  function automatic int stage_w(input int data_w, input int k);
    return data_w + k;
  endfunction

  function automatic int out_w(input int data_w, input int order);
    return stage_w(data_w, order);
  endfunction

endpackage

// File: rtl/iob_diff_n_stage.sv
// One backward-difference stage: diff = cur - prev, one bit wider so it never overflows.
module iob_diff_n_stage #(
  parameter int IN_W      = 8,
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic [IN_W-1:0] cur,
  input  logic [IN_W-1:0] prev,
  output logic [IN_W:0]   diff
);

  logic ext_cur;
  logic ext_prev;

  // Only the first stage can see unsigned raw samples; later stages are always signed
  assign ext_cur  = SIGNED_IN & cur[IN_W-1];
  assign ext_prev = SIGNED_IN & prev[IN_W-1];
  assign diff     = {ext_cur, cur} - {ext_prev, prev};

endmodule

// File: rtl/iob_diff_n.sv
// Streaming ORDER-th backward differentiator with per-channel history and valid/ready handshake.
module iob_diff_n
  import iob_diff_n_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ORDER    = 1,
  parameter int CHANNELS = 1,
  parameter bit SIGNED   = 1'b1,
  parameter int RST_VAL  = 0
) (
  input  logic                            clk_i,
  input  logic                            cke_i,
  input  logic                            arst_n_i,
  input  logic                            rst_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [ch_w(CHANNELS)-1:0]       in_ch_i,
  input  logic [DATA_W-1:0]               data_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [ch_w(CHANNELS)-1:0]       out_ch_o,
  output logic [out_w(DATA_W, ORDER)-1:0] data_o,
  output logic                            primed_o,
  output logic                            err_o
);

  localparam int CH_W  = ch_w(CHANNELS);
  localparam int HW    = out_w(DATA_W, ORDER);
  // Slots past CHANNELS are never written, so they stay at their reset constants
  localparam int NSLOT = 2 ** CH_W;
  localparam logic [DATA_W-1:0] RST_RAW   = DATA_W'(RST_VAL);
  localparam logic [HW-1:0]     HIST0_RST = HW'(RST_RAW);

  if (ORDER < 1 || ORDER > MAX_ORDER) begin : g_bad_order
    $error("iob_diff_n: ORDER must be within 1..%0d", MAX_ORDER);
  end

  logic [HW-1:0]     hist [NSLOT][ORDER];
  logic [PCNT_W-1:0] pcnt [NSLOT];
  logic [HW-1:0]     d    [ORDER+1];
  logic              ch_ok;
  logic              accept;

  assign ch_ok      = (int'(in_ch_i) < CHANNELS);
  assign in_ready_o = cke_i & ~rst_i & (~out_valid_o | out_ready_i);
  assign accept     = in_valid_i & in_ready_o;
  assign d[0]       = SIGNED ? HW'($signed(data_i)) : HW'(data_i);

  for (genvar k = 1; k <= ORDER; k++) begin : g_stage
    logic [DATA_W+k-1:0] diff;

    iob_diff_n_stage #(
      .IN_W      (DATA_W + k - 1),
      .SIGNED_IN ((k == 1) ? SIGNED : 1'b1)
    ) u_stage (
      .cur  (d[k-1][DATA_W+k-2:0]),
      .prev (hist[in_ch_i][k-1][DATA_W+k-2:0]),
      .diff (diff)
    );

    assign d[k] = HW'($signed(diff));
  end

  // Output register, channel histories and prime counters
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      out_valid_o <= 1'b0;
      out_ch_o    <= {CH_W{1'b0}};
      data_o      <= {HW{1'b0}};
      primed_o    <= 1'b0;
      err_o       <= 1'b0;
      for (int c = 0; c < NSLOT; c++) begin
        pcnt[c] <= {PCNT_W{1'b0}};
        for (int k = 0; k < ORDER; k++) hist[c][k] <= (k == 0) ? HIST0_RST : {HW{1'b0}};
      end
    end else if (cke_i) begin
      if (rst_i) begin
        out_valid_o <= 1'b0;
        out_ch_o    <= {CH_W{1'b0}};
        data_o      <= {HW{1'b0}};
        primed_o    <= 1'b0;
        err_o       <= 1'b0;
        for (int c = 0; c < NSLOT; c++) begin
          pcnt[c] <= {PCNT_W{1'b0}};
          for (int k = 0; k < ORDER; k++) hist[c][k] <= (k == 0) ? HIST0_RST : {HW{1'b0}};
        end
      end else begin
        err_o <= accept & ~ch_ok;
        if (accept && ch_ok) begin
          for (int k = 0; k < ORDER; k++) hist[in_ch_i][k] <= d[k];
          if (pcnt[in_ch_i] != PCNT_W'(ORDER)) pcnt[in_ch_i] <= pcnt[in_ch_i] + 3'd1;
          primed_o    <= (pcnt[in_ch_i] == PCNT_W'(ORDER));
          data_o      <= d[ORDER];
          out_ch_o    <= in_ch_i;
          out_valid_o <= 1'b1;
        end else if (out_ready_i) begin
          out_valid_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_iob_diff_n.sv
// Directed bench for iob_diff_n: three configurations sharing clock, reset and backpressure.
module tb_iob_diff_n;

  logic clk = 1'b0;
  logic arst_n, cke, rst, out_ready;

  // A: DATA_W=8 ORDER=2 CHANNELS=3 signed
  logic       a_valid, a_ready, a_ovalid, a_primed, a_err;
  logic [1:0] a_ch, a_och;
  logic [7:0] a_data;
  logic [9:0] a_dout;
  // B: DATA_W=8 ORDER=1 CHANNELS=2 unsigned
  logic       b_valid, b_ready, b_ovalid, b_primed, b_err, b_ch, b_och;
  logic [7:0] b_data;
  logic [8:0] b_dout;
  // C: DATA_W=8 ORDER=1 CHANNELS=1 signed
  logic       c_valid, c_ready, c_ovalid, c_primed, c_err, c_ch, c_och;
  logic [7:0] c_data;
  logic [8:0] c_dout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iob_diff_n #(.DATA_W(8), .ORDER(2), .CHANNELS(3), .SIGNED(1'b1), .RST_VAL(0)) u_a (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .rst_i(rst),
    .in_valid_i(a_valid), .in_ready_o(a_ready), .in_ch_i(a_ch), .data_i(a_data),
    .out_valid_o(a_ovalid), .out_ready_i(out_ready), .out_ch_o(a_och), .data_o(a_dout),
    .primed_o(a_primed), .err_o(a_err));

  iob_diff_n #(.DATA_W(8), .ORDER(1), .CHANNELS(2), .SIGNED(1'b0), .RST_VAL(0)) u_b (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .rst_i(rst),
    .in_valid_i(b_valid), .in_ready_o(b_ready), .in_ch_i(b_ch), .data_i(b_data),
    .out_valid_o(b_ovalid), .out_ready_i(out_ready), .out_ch_o(b_och), .data_o(b_dout),
    .primed_o(b_primed), .err_o(b_err));

  iob_diff_n #(.DATA_W(8), .ORDER(1), .CHANNELS(1), .SIGNED(1'b1), .RST_VAL(0)) u_c (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .rst_i(rst),
    .in_valid_i(c_valid), .in_ready_o(c_ready), .in_ch_i(c_ch), .data_i(c_data),
    .out_valid_o(c_ovalid), .out_ready_i(out_ready), .out_ch_o(c_och), .data_o(c_dout),
    .primed_o(c_primed), .err_o(c_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int sel, input logic [1:0] ch, input logic [7:0] v);
    case (sel)
      0:       begin a_valid = 1'b1; a_ch = ch;    a_data = v; end
      1:       begin b_valid = 1'b1; b_ch = ch[0]; b_data = v; end
      default: begin c_valid = 1'b1; c_ch = ch[0]; c_data = v; end
    endcase
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    c_valid = 1'b0;
  endtask

  task automatic exp_a(input string tag, input logic [9:0] d, input logic [1:0] ch, input logic p);
    chk({tag, ".valid"}, 32'(a_ovalid), 32'd1);
    chk({tag, ".data"}, 32'(a_dout), 32'(d));
    chk({tag, ".ch"}, 32'(a_och), 32'(ch));
    chk({tag, ".primed"}, 32'(a_primed), 32'(p));
  endtask

  task automatic exp_b(input string tag, input logic [8:0] d, input logic ch, input logic p);
    chk({tag, ".valid"}, 32'(b_ovalid), 32'd1);
    chk({tag, ".data"}, 32'(b_dout), 32'(d));
    chk({tag, ".ch"}, 32'(b_och), 32'(ch));
    chk({tag, ".primed"}, 32'(b_primed), 32'(p));
  endtask

  initial begin
    arst_n = 1'b0; cke = 1'b1; rst = 1'b0; out_ready = 1'b1;
    a_valid = 1'b0; a_ch = 2'd0; a_data = 8'd0;
    b_valid = 1'b0; b_ch = 1'b0; b_data = 8'd0;
    c_valid = 1'b0; c_ch = 1'b0; c_data = 8'd0;

    #2;
    chk("rst.valid", 32'(a_ovalid), 32'd0);
    chk("rst.data", 32'(a_dout), 32'd0);
    chk("rst.primed", 32'(a_primed), 32'd0);
    chk("rst.err", 32'(a_err), 32'd0);
    chk("rst.ready", 32'(a_ready), 32'd1);
    #10 arst_n = 1'b1;
    tick();

    // Second difference of squares settles to 2
    push(0, 2'd0, 8'd1);  exp_a("sq1", 10'd1, 2'd0, 1'b0);
    push(0, 2'd0, 8'd4);  exp_a("sq4", 10'd2, 2'd0, 1'b0);
    push(0, 2'd0, 8'd9);  exp_a("sq9", 10'd2, 2'd0, 1'b1);
    push(0, 2'd0, 8'd16); exp_a("sq16", 10'd2, 2'd0, 1'b1);

    // Out-of-range channel: pulse err, no output, histories untouched
    push(0, 2'd3, 8'd50);
    chk("bad.err", 32'(a_err), 32'd1);
    chk("bad.valid", 32'(a_ovalid), 32'd0);
    tick();
    chk("bad.err_clr", 32'(a_err), 32'd0);
    push(0, 2'd0, 8'd25);   exp_a("ch0_25", 10'd2, 2'd0, 1'b1);
    push(0, 2'd1, 8'd10);   exp_a("ch1_10", 10'd10, 2'd1, 1'b0);
    push(0, 2'd2, 8'hFD);   exp_a("ch2_m3", 10'h3FD, 2'd2, 1'b0);

    // Clock enable low freezes err_o and blocks input
    push(0, 2'd3, 8'd7);
    chk("cke.err_set", 32'(a_err), 32'd1);
    cke = 1'b0;
    #1 chk("cke.ready", 32'(a_ready), 32'd0);
    tick(); tick();
    chk("cke.err_hold", 32'(a_err), 32'd1);
    cke = 1'b1;
    tick();
    chk("cke.err_clr", 32'(a_err), 32'd0);

    // Backpressure on channel 1
    out_ready = 1'b0;
    a_valid = 1'b1; a_ch = 2'd1; a_data = 8'd25;
    tick();
    exp_a("bp.first", 10'd5, 2'd1, 1'b0);
    a_data = 8'd30;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.ready", 32'(a_ready), 32'd0);
      chk("bp.hold_data", 32'(a_dout), 32'd5);
      chk("bp.hold_valid", 32'(a_ovalid), 32'd1);
    end
    out_ready = 1'b1;
    #1 chk("bp.release_ready", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    exp_a("bp.resume", 10'h3F6, 2'd1, 1'b1);
    push(0, 2'd1, 8'd33); exp_a("bp.next", 10'h3FE, 2'd1, 1'b1);

    // Synchronous clear mid-stream
    rst = 1'b1; tick(); rst = 1'b0;
    push(0, 2'd0, 8'd1);
    push(0, 2'd0, 8'd4);
    push(0, 2'd0, 8'd9);  exp_a("srst.pre", 10'd2, 2'd0, 1'b1);
    rst = 1'b1;
    #1 chk("srst.ready", 32'(a_ready), 32'd0);
    tick();
    rst = 1'b0;
    chk("srst.valid", 32'(a_ovalid), 32'd0);
    chk("srst.data", 32'(a_dout), 32'd0);
    chk("srst.primed", 32'(a_primed), 32'd0);
    push(0, 2'd0, 8'd16); exp_a("srst.ch0", 10'h010, 2'd0, 1'b0);
    push(0, 2'd1, 8'd5);  exp_a("srst.ch1", 10'h005, 2'd1, 1'b0);

    // Asynchronous reset between clock edges
    #2 arst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(a_ovalid), 32'd0);
    chk("arst.data", 32'(a_dout), 32'd0);
    arst_n = 1'b1;
    tick();

    // Unsigned first difference and two-channel interleave
    push(1, 2'd0, 8'd0);   exp_b("u0", 9'h000, 1'b0, 1'b0);
    push(1, 2'd0, 8'd255); exp_b("u255", 9'h0FF, 1'b0, 1'b1);
    push(1, 2'd0, 8'd0);   exp_b("u0b", 9'h101, 1'b0, 1'b1);
    push(1, 2'd0, 8'd10);  exp_b("il0a", 9'h00A, 1'b0, 1'b1);
    push(1, 2'd1, 8'd100); exp_b("il1a", 9'h064, 1'b1, 1'b0);
    push(1, 2'd0, 8'd15);  exp_b("il0b", 9'h005, 1'b0, 1'b1);
    push(1, 2'd1, 8'd90);  exp_b("il1b", 9'h1F6, 1'b1, 1'b1);
    tick();
    chk("b.drain", 32'(b_ovalid), 32'd0);

    // Signed first difference at the extremes
    push(2, 2'd0, 8'd127);
    chk("s127.data", 32'(c_dout), 32'h07F);
    chk("s127.primed", 32'(c_primed), 32'd0);
    push(2, 2'd0, 8'h80);
    chk("sm128.data", 32'(c_dout), 32'h101);
    chk("sm128.primed", 32'(c_primed), 32'd1);
    chk("sm128.valid", 32'(c_ovalid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
